// File: rtl/shift_reg_universal_negclk.sv
// rtl/shift_reg_universal_negclk.sv - universal shift register with multi-step engine
//
// WIDTH-bit register bank with complementary outputs, parallel load, eight
// single-step operations and a multi-step shift engine (Busy/Done handshake).
// NEG_CLK selects whether state updates on the falling (1) or rising (0) edge.
// Optional feature macro: SHREG_PARITY_EN adds a registered Parity output (^Q).
//
// Ports:
//   Clk      clock, active edge chosen by NEG_CLK
//   Clr      synchronous active-high reset, sampled on the active edge
//   En       single-step enable (idle only)
//   Mode     operation select: hold/load/shl/shr/rotl/rotr/asr/clear
//   D        parallel load data
//   SerInL   serial input entering at the MSB
//   SerInR   serial input entering at the LSB
//   Start    begin a multi-step operation (accepted only when idle)
//   Amt      multi-step count
//   Q, Qbar  register contents and complement
//   SerOutL  Q[WIDTH-1];  SerOutR  Q[0]
//   Busy     multi-step operation in progress
//   Parity   ^Q (only with SHREG_PARITY_EN)
//   Done     one-cycle completion pulse

module shift_reg_universal_negclk #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 4,
  parameter int               NEG_CLK   = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic             Start,
  input  logic [AMT_W-1:0] Amt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Busy,
`ifdef SHREG_PARITY_EN
  output logic             Parity,
`endif
  output logic             Done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // All state sits on the rising edge of act_clk; inverting Clk yields
  // falling-edge behaviour without duplicating the sequential logic.
  logic act_clk;
  assign act_clk = (NEG_CLK != 0) ? ~Clk : Clk;

  state_t           state, state_next;
  logic [AMT_W-1:0] cnt, cnt_next;
  logic [2:0]       op, op_next;
  logic [WIDTH-1:0] q_next;
  logic             done_next;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = cur;
      3'b001:  r = ld;
      3'b010:  r = {cur[WIDTH-2:0], sr};
      3'b011:  r = {sl, cur[WIDTH-1:1]};
      3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  r = {cur[0], cur[WIDTH-1:1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign is_shift = (Mode >= 3'b010) && (Mode <= 3'b110);

  // State register
  always_ff @(posedge act_clk) begin
    if (Clr) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (Start && is_shift && (Amt != '0)) state_next = S_RUN;
      S_RUN:  if (cnt == AMT_W'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic (registered state only, no input-to-output path)
  always_comb begin
    Busy = (state == S_RUN);
  end

  // Datapath next values
  always_comb begin
    q_next    = Q;
    cnt_next  = cnt;
    op_next   = op;
    done_next = 1'b0;
    if (state == S_RUN) begin
      // Serial inputs are sampled live on every step; the op is the latched one.
      q_next   = apply_op(op, Q, D, SerInL, SerInR);
      cnt_next = cnt - 1'b1;
      if (cnt == AMT_W'(1)) done_next = 1'b1;
    end else if (Start) begin
      if (is_shift) begin
        if (Amt != '0) begin
          cnt_next = Amt;
          op_next  = Mode;
        end else begin
          done_next = 1'b1;
        end
      end else begin
        // hold/load/clear complete at the Start edge itself
        q_next    = apply_op(Mode, Q, D, SerInL, SerInR);
        done_next = 1'b1;
      end
    end else if (En) begin
      q_next = apply_op(Mode, Q, D, SerInL, SerInR);
    end
  end

  always_ff @(posedge act_clk) begin
    if (Clr) begin
      Q    <= RESET_VAL;
      cnt  <= '0;
      op   <= 3'b000;
      Done <= 1'b0;
    end else begin
      Q    <= q_next;
      cnt  <= cnt_next;
      op   <= op_next;
      Done <= done_next;
    end
  end

`ifdef SHREG_PARITY_EN
  always_ff @(posedge act_clk) begin
    if (Clr) Parity <= ^RESET_VAL;
    else     Parity <= ^q_next;
  end
`endif

  assign Qbar    = ~Q;
  assign SerOutL = Q[WIDTH-1];
  assign SerOutR = Q[0];

endmodule

// File: tb/tb_shift_reg_universal_negclk.sv
// tb/tb_shift_reg_universal_negclk.sv - directed self-checking bench for shift_reg_universal_negclk

module tb_shift_reg_universal_negclk;

  logic       clk;
  logic       clr, en, sl, sr, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amt;
  logic [7:0] q, qbar;
  logic       sol, sor, busy, done;
`ifdef SHREG_PARITY_EN
  logic       parity, parity_p;
`endif

  logic       clr_p, en_p;
  logic [2:0] mode_p;
  logic [7:0] d_p;
  logic [7:0] q_p, qbar_p;
  logic       sol_p, sor_p, busy_p, done_p;

  int compares   = 0;
  int mismatches = 0;
  int n;

  shift_reg_universal_negclk #(.WIDTH(8), .AMT_W(4), .NEG_CLK(1), .RESET_VAL(8'h00)) dut_n (
    .Clk(clk), .Clr(clr), .En(en), .Mode(mode), .D(d), .SerInL(sl), .SerInR(sr),
    .Start(start), .Amt(amt), .Q(q), .Qbar(qbar), .SerOutL(sol), .SerOutR(sor),
    .Busy(busy),
`ifdef SHREG_PARITY_EN
    .Parity(parity),
`endif
    .Done(done)
  );

  shift_reg_universal_negclk #(.WIDTH(8), .AMT_W(4), .NEG_CLK(0), .RESET_VAL(8'h00)) dut_p (
    .Clk(clk), .Clr(clr_p), .En(en_p), .Mode(mode_p), .D(d_p), .SerInL(1'b0), .SerInR(1'b0),
    .Start(1'b0), .Amt(4'd0), .Q(q_p), .Qbar(qbar_p), .SerOutL(sol_p), .SerOutR(sor_p),
    .Busy(busy_p),
`ifdef SHREG_PARITY_EN
    .Parity(parity_p),
`endif
    .Done(done_p)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      mismatches++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'b001; d = v; en = 1'b1;
    tick();
    en = 1'b0; mode = 3'b000;
  endtask

  task automatic step(input logic [2:0] m, input logic [7:0] exp, input string tag);
    mode = m; en = 1'b1;
    tick();
    en = 1'b0;
    check_val(tag, q, exp);
  endtask

  // Runs a multi-step op and returns the number of edges after the Start edge
  // until Done is seen (bounded).
  task automatic run_multi(input logic [2:0] m, input logic [3:0] a, output int edges);
    mode = m; amt = a; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000; amt = 4'd0;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
      edges++;
    end
  endtask

  initial begin
    clr = 1'b1; en = 0; sl = 0; sr = 0; start = 0; mode = 0; d = 0; amt = 0;
    clr_p = 1'b1; en_p = 0; mode_p = 0; d_p = 0;

    // reset
    tick(); tick();
    check_val("rst_q", q, 8'h00);
    check_val("rst_qbar", qbar, 8'hFF);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    clr = 1'b0;

    // load on falling edge only
    mode = 3'b001; d = 8'hA5; en = 1'b1;
    @(posedge clk); #1;
    check_val("rise_nochg", q, 8'h00);
    @(negedge clk); #1;
    en = 1'b0;
    check_val("load_q", q, 8'hA5);
    check_val("load_qbar", qbar, 8'h5A);
    check_val("load_sol", sol, 1'b1);
    check_val("load_sor", sor, 1'b1);

    // single-step ops
    load(8'h96);
    sr = 1'b1; step(3'b010, 8'h2D, "shl");
    step(3'b101, 8'h96, "rotr");
    step(3'b110, 8'hCB, "asr");
    step(3'b100, 8'h97, "rotl");
    sl = 1'b0; step(3'b011, 8'h4B, "shr");
    step(3'b000, 8'h4B, "hold");
    mode = 3'b001; d = 8'h00; en = 1'b0;
    tick();
    check_val("en_off", q, 8'h4B);
    sr = 1'b0;

    // rotl x3 with En/Mode toggled while busy
    load(8'h81);
    mode = 3'b100; amt = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("rl_start_q", q, 8'h81);
    check_val("rl_start_busy", busy, 1'b1);
    check_val("rl_start_done", done, 1'b0);
    en = 1'b1; mode = 3'b001; d = 8'h00; amt = 4'd7;
    tick();
    check_val("rl_s1", q, 8'h03);
    mode = 3'b111;
    tick();
    check_val("rl_s2", q, 8'h06);
    check_val("rl_s2_busy", busy, 1'b1);
    check_val("rl_s2_done", done, 1'b0);
    tick();
    check_val("rl_s3", q, 8'h0C);
    check_val("rl_s3_busy", busy, 1'b0);
    check_val("rl_s3_done", done, 1'b1);
    en = 1'b0; mode = 3'b000;
    tick();
    check_val("rl_done_clr", done, 1'b0);
    check_val("rl_hold", q, 8'h0C);

    // asr saturation, shl full fill
    load(8'h80);
    run_multi(3'b110, 4'd10, n);
    check_val("asr_edges", n, 10);
    check_val("asr_q", q, 8'hFF);
    sr = 1'b0;
    run_multi(3'b010, 4'd9, n);
    check_val("shl_edges", n, 9);
    check_val("shl_q", q, 8'h00);

    // Clr aborts an operation
    load(8'hF0);
    sl = 1'b1; mode = 3'b011; amt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    check_val("ab_s1", q, 8'hF8);
    tick();
    check_val("ab_s2", q, 8'hFC);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("ab_q", q, 8'h00);
    check_val("ab_busy", busy, 1'b0);
    check_val("ab_done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("ab_no_done", done, 1'b0);
    end
    sl = 1'b0;

    // Amt=0, then Start accepted while Done=1 (clear completes at once)
    load(8'h5A);
    mode = 3'b010; amt = 4'd0; start = 1'b1;
    tick();
    check_val("a0_done", done, 1'b1);
    check_val("a0_q", q, 8'h5A);
    check_val("a0_busy", busy, 1'b0);
    mode = 3'b111;
    tick();
    start = 1'b0; mode = 3'b000;
    check_val("clr_op_q", q, 8'h00);
    check_val("clr_op_done", done, 1'b1);
    check_val("clr_op_busy", busy, 1'b0);
    tick();
    check_val("clr_op_done_off", done, 1'b0);

`ifdef SHREG_PARITY_EN
    load(8'h07);
    check_val("par_load", parity, 1'b1);
    step(3'b100, 8'h0E, "par_rotl_q");
    check_val("par_rotl", parity, 1'b1);
    step(3'b111, 8'h00, "par_clear_q");
    check_val("par_clear", parity, 1'b0);
`endif

    // rising-edge instance
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("p_rst_q", q_p, 8'h00);
    clr_p = 1'b0;
    mode_p = 3'b001; d_p = 8'hC3; en_p = 1'b1;
    @(negedge clk); #1;
    check_val("p_fall_nochg", q_p, 8'h00);
    @(posedge clk); #1;
    en_p = 1'b0;
    check_val("p_load", q_p, 8'hC3);
    check_val("p_qbar", qbar_p, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal_negclk.md
Name: shift_reg_universal_negclk

Overview:
- Parametrised successor to the single-bit negative-edge D flip-flop: a WIDTH-bit register bank with complementary outputs, parallel load, eight operating modes and a multi-step shift engine with a Busy/Done handshake.
- Datapath building block for serial/parallel converters, barrel-style shifters built over time, and pattern generators.
- Edge polarity is selectable, so the same block serves negative-edge and positive-edge clock domains.

Parameters:
- WIDTH, 8, register width in bits (minimum 2).
- AMT_W, 4, width of the multi-step shift amount.
- NEG_CLK, 1; 1 = all state updates on the falling edge of Clk, 0 = rising edge.
- RESET_VAL, 0, value loaded into Q by reset (WIDTH bits).

Ports:
- Clk  in  1  clock; active edge selected by NEG_CLK.
- Clr  in  1  synchronous, active-high reset, sampled on the active Clk edge.
- En  in  1  single-step enable.
- Mode  in  3  operation select (encoding below).
- D  in  WIDTH  parallel load data.
- SerInL  in  1  serial input entering at the MSB.
- SerInR  in  1  serial input entering at the LSB.
- Start  in  1  begin a multi-step operation.
- Amt  in  AMT_W  step count for a multi-step operation.
- Q  out  WIDTH  register contents.
- Qbar  out  WIDTH  always ~Q.
- SerOutL  out  1  Q[WIDTH-1], combinational.
- SerOutR  out  1  Q[0], combinational.
- Busy  out  1  multi-step operation in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: Clr=1 at an active edge sets Q=RESET_VAL, Qbar=~RESET_VAL, Busy=0, Done=0 and the step counter to 0.
  - Clr overrides every other input.
  - Clr mid-operation aborts the operation; no Done pulse is produced.
- Mode encoding:
  - 000 hold
  - 001 load D
  - 010 shl: Q <= {Q[W-2:0], SerInR}
  - 011 shr: Q <= {SerInL, Q[W-1:1]}
  - 100 rotl
  - 101 rotr
  - 110 asr: MSB replicated
  - 111 clear: Q <= 0
- Idle (Busy=0), Start=0:
  - En=1 applies Mode once at the active edge.
  - En=0 holds Q.
  - Done=0.
- Start accepted only when Busy=0; Start has priority over En.
- Start with Mode in 010..110 and Amt>0:
  - At the Start edge: latch Mode and Amt; Busy<=1; counter<=Amt; Q unchanged.
  - Each following active edge performs one step of the latched op and decrements the counter.
  - On the edge performing the last step: Busy<=0, Done<=1.
  - Done goes high exactly Amt edges after the Start edge.
- Start with a shift mode and Amt=0: Q unchanged, Busy stays 0, Done<=1 at the next edge.
- Start with Mode 000/001/111: op executes once at the Start edge, Done<=1 at the same edge, Busy stays 0.
- While Busy=1: En, Mode, D, Amt and Start are ignored. SerInL/SerInR are sampled live at each step.
- Amt > WIDTH is legal:
  - shl/shr fill completely with serial input.
  - Rotations wrap modulo WIDTH.
  - asr saturates to all-sign.
- Done is a single-cycle pulse, cleared at the next active edge unless a new completion occurs. A Start in the same cycle Done=1 is accepted.
- No combinational path from inputs to Q, Busy or Done.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined: adds output port Parity (1 bit), registered, equal to ^Q after every update. Reset value is ^RESET_VAL.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8, NEG_CLK=1: Clr=1 for 2 falling edges -> Q=8'h00, Qbar=8'hFF, Busy=0, Done=0; no change on rising edges.
- Mode=001, D=8'hA5, En=1, one falling edge -> Q=8'hA5, Qbar=8'h5A, SerOutL=1, SerOutR=1.
- Q=8'h81, Start=1, Mode=100, Amt=3 -> Busy=1 for 3 edges, Q=8'h0C, Done=1 for exactly one edge; En and Mode toggled during Busy have no effect.
- Q=8'h80, Start, Mode=110, Amt=10 -> Q=8'hFF. Q=8'hFF, Start, Mode=010, SerInR=0, Amt=9 -> Q=8'h00. Each Done lands Amt edges after its Start.
- Start, Mode=011, Amt=5, Clr=1 after the 2nd step -> Q=RESET_VAL, Busy=0, no Done pulse. Start with Amt=0 -> Done next edge, Q unchanged.
- With SHREG_PARITY_EN: load 8'h07 -> Parity=1, then rotl -> Parity=1, then clear -> Parity=0. Rerun with NEG_CLK=0 -> all updates on rising edges.
